seg7_scan_display: RTL and testbench

Parametrised, time-multiplexed driver for a common-anode seven-segment display bank. It generalises the board's fixed 4-digit scan to NUM_DIGITS digits and adds per-digit blanking and blinking, global PWM brightness, and tear-free shadow-register updates applied only at frame boundaries. It sits between the alarm-clock controller's display data and the board pins `seg`, `an` and `dp`.

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/hex_to_seg7.sv | 33 +++
 rtl/seg7_scan_display.sv | 188 ++++++++++++++++++
 tb/tb_seg7_scan_display.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver.
// Segment vectors are ordered {g,f,e,d,c,b,a}; a 0 bit lights the segment
// (common-anode wiring).
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG7_BLANK = 7'h7F;

  localparam seg7_t SEG7_HEX_0 = 7'b1000000;
  localparam seg7_t SEG7_HEX_1 = 7'b1111001;
  localparam seg7_t SEG7_HEX_2 = 7'b0100100;
  localparam seg7_t SEG7_HEX_3 = 7'b0110000;
  localparam seg7_t SEG7_HEX_4 = 7'b0011001;
  localparam seg7_t SEG7_HEX_5 = 7'b0010010;
  localparam seg7_t SEG7_HEX_6 = 7'b0000010;
  localparam seg7_t SEG7_HEX_7 = 7'b1111000;
  localparam seg7_t SEG7_HEX_8 = 7'b0000000;
  localparam seg7_t SEG7_HEX_9 = 7'b0010000;
  localparam seg7_t SEG7_HEX_A = 7'b0001000;
  localparam seg7_t SEG7_HEX_B = 7'b0000011;
  localparam seg7_t SEG7_HEX_C = 7'b1000110;
  localparam seg7_t SEG7_HEX_D = 7'b0100001;
  localparam seg7_t SEG7_HEX_E = 7'b0000110;
  localparam seg7_t SEG7_HEX_F = 7'b0001110;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low gfedcba segment decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Look up the segment pattern for the nibble; unknown codes go dark.
  always_comb begin
    seg = SEG7_BLANK;
    case (hex)
      4'h0:    seg = SEG7_HEX_0;
      4'h1:    seg = SEG7_HEX_1;
      4'h2:    seg = SEG7_HEX_2;
      4'h3:    seg = SEG7_HEX_3;
      4'h4:    seg = SEG7_HEX_4;
      4'h5:    seg = SEG7_HEX_5;
      4'h6:    seg = SEG7_HEX_6;
      4'h7:    seg = SEG7_HEX_7;
      4'h8:    seg = SEG7_HEX_8;
      4'h9:    seg = SEG7_HEX_9;
      4'hA:    seg = SEG7_HEX_A;
      4'hB:    seg = SEG7_HEX_B;
      4'hC:    seg = SEG7_HEX_C;
      4'hD:    seg = SEG7_HEX_D;
      4'hE:    seg = SEG7_HEX_E;
      4'hF:    seg = SEG7_HEX_F;
      default: seg = SEG7_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed common-anode seven-segment driver with per-digit blank,
// blink and decimal point, global PWM brightness and frame-aligned shadow
// updates. All pins are registered, so they show the previous cycle's scan
// position.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_BITS   = 16,
  parameter int BLINK_BITS = 6
) (
  input  logic                    MCLK,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   blink,
  input  logic [3:0]              brightness,
  input  logic                    update,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp,
  output logic                    busy,
  output logic                    frame_start
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0]      IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]      IDX_ONE   = IDX_W'(1'b1);
  localparam logic [DIV_BITS-1:0]   PRE_LAST  = {DIV_BITS{1'b1}};
  localparam logic [DIV_BITS-1:0]   PRE_ZERO  = {DIV_BITS{1'b0}};
  localparam logic [DIV_BITS-1:0]   PRE_ONE   = DIV_BITS'(1'b1);
  localparam logic [BLINK_BITS-1:0] FCNT_ZERO = {BLINK_BITS{1'b0}};
  localparam logic [BLINK_BITS-1:0] FCNT_ONE  = BLINK_BITS'(1'b1);
  localparam logic [NUM_DIGITS-1:0] ALL_ONES  = {NUM_DIGITS{1'b1}};
  localparam logic [NUM_DIGITS-1:0] ALL_ZEROS = {NUM_DIGITS{1'b0}};

  // Scan position
  logic [DIV_BITS-1:0]   pre_r;
  logic [IDX_W-1:0]      idx_r;
  logic [BLINK_BITS-1:0] fcnt_r;

  // Active (displayed) and pending (shadow) display state
  logic [4*NUM_DIGITS-1:0] act_digits_r, pend_digits_r;
  logic [NUM_DIGITS-1:0]   act_dp_r, pend_dp_r;
  logic [NUM_DIGITS-1:0]   act_blank_r, pend_blank_r;
  logic [NUM_DIGITS-1:0]   act_blink_r, pend_blink_r;
  logic                    busy_r;

  // Output registers
  logic [6:0]            seg_r;
  logic [NUM_DIGITS-1:0] an_r;
  logic                  dp_r;
  logic                  frame_start_r;

  // Combinational view of the current scan slot
  logic                  slot_end_s;
  logic                  frame_end_s;
  logic [3:0]            phase_s;
  logic                  blink_off_s;
  logic [3:0]            nibble_s;
  logic                  dp_sel_s;
  logic                  blank_sel_s;
  logic                  blink_sel_s;
  logic [NUM_DIGITS-1:0] an_sel_s;
  logic                  on_s;
  logic [6:0]            seg_dec_s;

  assign slot_end_s  = (pre_r == PRE_LAST);
  assign frame_end_s = slot_end_s && (idx_r == IDX_LAST);
  assign phase_s     = pre_r[DIV_BITS-1 -: 4];
  assign blink_off_s = fcnt_r[BLINK_BITS-1];

  // Select the active attributes of the digit currently being scanned.
  always_comb begin
    nibble_s    = 4'h0;
    dp_sel_s    = 1'b0;
    blank_sel_s = 1'b1;
    blink_sel_s = 1'b0;
    an_sel_s    = ALL_ONES;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_r == IDX_W'(i)) begin
        nibble_s    = act_digits_r[4*i +: 4];
        dp_sel_s    = act_dp_r[i];
        blank_sel_s = act_blank_r[i];
        blink_sel_s = act_blink_r[i];
        an_sel_s[i] = 1'b0;
      end else begin
        an_sel_s[i] = 1'b1;
      end
    end
  end

  assign on_s = !blank_sel_s && !(blink_sel_s && blink_off_s) &&
                (phase_s <= brightness);

  hex_to_seg7 u_dec (
    .hex (nibble_s),
    .seg (seg_dec_s)
  );

  // Advance prescaler, digit index and frame counter.
  always_ff @(posedge MCLK) begin
    if (!reset) begin
      pre_r  <= PRE_ZERO;
      idx_r  <= IDX_ZERO;
      fcnt_r <= FCNT_ZERO;
    end else begin
      pre_r <= pre_r + PRE_ONE;
      if (frame_end_s) begin
        idx_r  <= IDX_ZERO;
        fcnt_r <= fcnt_r + FCNT_ONE;
      end else if (slot_end_s) begin
        idx_r  <= idx_r + IDX_ONE;
        fcnt_r <= fcnt_r;
      end else begin
        idx_r  <= idx_r;
        fcnt_r <= fcnt_r;
      end
    end
  end

  // Capture updates into the shadow and swap them in only at a frame edge,
  // so a frame never mixes old and new digits.
  always_ff @(posedge MCLK) begin
    if (!reset) begin
      act_digits_r  <= {(4*NUM_DIGITS){1'b0}};
      act_dp_r      <= ALL_ZEROS;
      act_blank_r   <= ALL_ONES;
      act_blink_r   <= ALL_ZEROS;
      pend_digits_r <= {(4*NUM_DIGITS){1'b0}};
      pend_dp_r     <= ALL_ZEROS;
      pend_blank_r  <= ALL_ONES;
      pend_blink_r  <= ALL_ZEROS;
      busy_r        <= 1'b0;
    end else if (frame_end_s) begin
      // A strobe on the boundary itself wins over any older pending value.
      if (update) begin
        act_digits_r <= digits;
        act_dp_r     <= dp_in;
        act_blank_r  <= blank;
        act_blink_r  <= blink;
      end else if (busy_r) begin
        act_digits_r <= pend_digits_r;
        act_dp_r     <= pend_dp_r;
        act_blank_r  <= pend_blank_r;
        act_blink_r  <= pend_blink_r;
      end else begin
        act_digits_r <= act_digits_r;
        act_dp_r     <= act_dp_r;
        act_blank_r  <= act_blank_r;
        act_blink_r  <= act_blink_r;
      end
      busy_r <= 1'b0;
    end else if (update) begin
      pend_digits_r <= digits;
      pend_dp_r     <= dp_in;
      pend_blank_r  <= blank;
      pend_blink_r  <= blink;
      busy_r        <= 1'b1;
    end else begin
      busy_r <= busy_r;
    end
  end

  // Register the pins; a disabled slot drives everything dark.
  always_ff @(posedge MCLK) begin
    if (!reset) begin
      seg_r         <= SEG7_BLANK;
      an_r          <= ALL_ONES;
      dp_r          <= 1'b1;
      frame_start_r <= 1'b0;
    end else begin
      seg_r         <= on_s ? seg_dec_s : SEG7_BLANK;
      an_r          <= on_s ? an_sel_s : ALL_ONES;
      dp_r          <= on_s ? !dp_sel_s : 1'b1;
      frame_start_r <= (pre_r == PRE_ZERO) && (idx_r == IDX_ZERO);
    end
  end

  assign seg         = seg_r;
  assign an          = an_r;
  assign dp          = dp_r;
  assign busy        = busy_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Self-checking bench for seg7_scan_display with a cycle-count based model.
module tb_seg7_scan_display;

  localparam int ND    = 4;
  localparam int DB    = 4;
  localparam int BB    = 2;
  localparam int SLOT  = 1 << DB;
  localparam int FRAME = ND * SLOT;

  logic        MCLK = 1'b0;
  logic        reset;
  logic [15:0] digits;
  logic [3:0]  dp_in, blank, blink, brightness;
  logic        update;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp, busy, frame_start;

  int checks = 0;
  int errors = 0;

  // Reference model: m_t is the number of cycles since reset release for the
  // state about to be clocked; the m_an..m_fs values are the pins expected
  // after the most recent edge.
  int          m_t;
  logic [15:0] m_act_dig, m_pend_dig;
  logic [3:0]  m_act_dp, m_pend_dp, m_act_blank, m_pend_blank, m_act_blink, m_pend_blink;
  logic        m_busy;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  logic        m_dp, m_fs;

  seg7_scan_display #(.NUM_DIGITS(ND), .DIV_BITS(DB), .BLINK_BITS(BB)) dut (
    .MCLK(MCLK), .reset(reset), .digits(digits), .dp_in(dp_in), .blank(blank),
    .blink(blink), .brightness(brightness), .update(update), .seg(seg), .an(an),
    .dp(dp), .busy(busy), .frame_start(frame_start)
  );

  always #5 MCLK = ~MCLK;

  function automatic logic [6:0] decode(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  task automatic model_edge();
    int pre, idx, frm;
    logic on;
    if (!reset) begin
      m_t = 0;
      m_act_dig = 16'h0; m_act_dp = 4'h0; m_act_blank = 4'hF; m_act_blink = 4'h0;
      m_pend_dig = 16'h0; m_pend_dp = 4'h0; m_pend_blank = 4'hF; m_pend_blink = 4'h0;
      m_busy = 1'b0; m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1; m_fs = 1'b0;
    end else begin
      pre = m_t % SLOT;
      idx = (m_t / SLOT) % ND;
      frm = m_t / FRAME;
      on = !m_act_blank[idx] && !(m_act_blink[idx] && ((frm % (1 << BB)) >= (1 << (BB - 1))))
           && ((pre >> (DB - 4)) <= int'(brightness));
      m_an  = on ? ~(4'b0001 << idx) : 4'hF;
      m_seg = on ? decode(m_act_dig[4*idx +: 4]) : 7'h7F;
      m_dp  = on ? ~m_act_dp[idx] : 1'b1;
      m_fs  = ((m_t % FRAME) == 0);
      if ((m_t % FRAME) == FRAME - 1) begin
        if (update) begin
          m_act_dig = digits; m_act_dp = dp_in; m_act_blank = blank; m_act_blink = blink;
        end else if (m_busy) begin
          m_act_dig = m_pend_dig; m_act_dp = m_pend_dp;
          m_act_blank = m_pend_blank; m_act_blink = m_pend_blink;
        end
        m_busy = 1'b0;
      end else if (update) begin
        m_pend_dig = digits; m_pend_dp = dp_in; m_pend_blank = blank; m_pend_blink = blink;
        m_busy = 1'b1;
      end
      m_t++;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge MCLK);
    @(negedge MCLK);
  endtask

  task automatic test_reset();
    reset = 1'b0; update = 1'b0; brightness = 4'hF;
    digits = 16'($urandom); dp_in = 4'hF; blank = 4'h0; blink = 4'h0;
    repeat (3) tick();
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an: got %b want 1111", an); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %b want 1111111", seg); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b want 1", dp); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b want 0", frame_start); end
  endtask

  task automatic test_scan_order();
    logic [3:0] exp_nib [4];
    logic [3:0] exp_an;
    int n;
    exp_nib[0] = 4'h4; exp_nib[1] = 4'h3; exp_nib[2] = 4'h2; exp_nib[3] = 4'h1;
    reset = 1'b1; digits = 16'h1234; dp_in = 4'h0; blank = 4'h0; blink = 4'h0;
    update = 1'b1; tick(); update = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL scan_busy: got %b want 1", busy); end
    n = 0;
    while (m_busy && n < 2 * FRAME) begin tick(); n++; end
    checks++; if (n >= 2 * FRAME) begin errors++; $display("FAIL scan_apply_timeout: cycles %0d", n); end
    tick();
    for (int c = 0; c < FRAME; c++) begin
      exp_an = ~(4'b0001 << (c / SLOT));
      checks++;
      if (an !== exp_an || seg !== decode(exp_nib[c / SLOT]) || frame_start !== (c == 0)) begin
        errors++;
        $display("FAIL scan_c%0d: an=%b seg=%b fs=%b want an=%b seg=%b fs=%b", c, an, seg,
                 frame_start, exp_an, decode(exp_nib[c / SLOT]), (c == 0));
      end
      tick();
    end
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL scan_fs_period: got %b want 1", frame_start); end
  endtask

  task automatic test_shadow();
    int n;
    // Repeated update: last write wins.
    while (m_t % FRAME != 10) tick();
    digits = 16'h8888; update = 1'b1; tick(); update = 1'b0;
    while (m_t % FRAME != 30) tick();
    digits = 16'hAAAA; update = 1'b1; tick(); update = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL shadow_busy2: got %b want 1", busy); end
    n = 0;
    while (m_busy && n < 2 * FRAME) begin
      checks++; if (seg === 7'b0000000) begin errors++; $display("FAIL shadow_early8: seg=%b", seg); end
      tick(); n++;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL shadow_busy_clear2: got %b want 0", busy); end
    tick();
    for (int c = 0; c < FRAME; c++) begin
      checks++; if (seg !== 7'b0001000) begin errors++; $display("FAIL shadow_A_c%0d: seg=%b want 0001000", c, seg); end
      tick();
    end
    // Single update: old value held until the boundary.
    while (m_t % FRAME != 40) tick();
    digits = 16'h8888; update = 1'b1; tick(); update = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL shadow_busy1: got %b want 1", busy); end
    n = 0;
    while (m_busy && n < 2 * FRAME) begin
      checks++; if (seg !== 7'b0001000) begin errors++; $display("FAIL shadow_hold: seg=%b want 0001000", seg); end
      tick(); n++;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL shadow_busy_clear1: got %b want 0", busy); end
    tick();
    checks++; if (seg !== 7'b0000000 || an !== 4'b1110) begin
      errors++; $display("FAIL shadow_8_visible: seg=%b an=%b want 0000000 1110", seg, an);
    end
  endtask

  task automatic test_boundary_update();
    while (m_t % FRAME != 20) tick();
    digits = 16'hFFFF; update = 1'b1; tick(); update = 1'b0;
    while (m_t % FRAME != FRAME - 1) tick();
    digits = 16'h5A5A; update = 1'b1; tick(); update = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bnd_busy: got %b want 0", busy); end
    tick();
    checks++; if (seg !== 7'b0001000 || an !== 4'b1110 || frame_start !== 1'b1) begin
      errors++; $display("FAIL bnd_visible: seg=%b an=%b fs=%b want 0001000 1110 1", seg, an, frame_start);
    end
    while (m_t % FRAME != SLOT) tick();
    tick();
    checks++; if (seg !== 7'b0010010 || an !== 4'b1101) begin
      errors++; $display("FAIL bnd_digit1: seg=%b an=%b want 0010010 1101", seg, an);
    end
  endtask

  task automatic test_brightness();
    int pos, cnt;
    logic on;
    for (int k = 0; k < 5; k++) begin
      brightness = (k == 0) ? 4'd3 : 4'($urandom_range(0, 15));
      while (m_t % FRAME != 0) tick();
      cnt = 0;
      for (int c = 0; c < FRAME; c++) begin
        pos = m_t % SLOT;
        tick();
        on = (an !== 4'hF);
        checks++; if (on !== (pos <= int'(brightness))) begin
          errors++; $display("FAIL bright_%0d_pos%0d: on=%b want %b", brightness, pos, on, (pos <= int'(brightness)));
        end
        cnt += int'(on);
      end
      checks++; if (cnt != (int'(brightness) + 1) * ND * (SLOT / 16)) begin
        errors++; $display("FAIL bright_%0d_count: got %0d want %0d", brightness, cnt,
                           (int'(brightness) + 1) * ND * (SLOT / 16));
      end
    end
    brightness = 4'hF;
  endtask

  task automatic test_blank_blink_dp();
    int st, lit0, n;
    digits = 16'h0123; blink = 4'b0001; blank = 4'b0100; dp_in = 4'b1000; brightness = 4'hF;
    update = 1'b1; tick(); update = 1'b0;
    n = 0;
    while (m_busy && n < 2 * FRAME) begin tick(); n++; end
    while (m_t % FRAME != 0) tick();
    lit0 = 0;
    for (int c = 0; c < 8 * FRAME; c++) begin
      st = m_t;
      tick();
      lit0 += int'(an === 4'b1110);
      checks++; if (an[2] !== 1'b1) begin errors++; $display("FAIL blank_d2_t%0d: an=%b", st, an); end
      checks++; if (dp !== ((an === 4'b0111) ? 1'b0 : 1'b1)) begin
        errors++; $display("FAIL dp_t%0d: dp=%b an=%b", st, dp, an);
      end
      checks++; if (an !== m_an || seg !== m_seg || dp !== m_dp) begin
        errors++; $display("FAIL bbd_t%0d: an=%b seg=%b dp=%b want %b %b %b", st, an, seg, dp, m_an, m_seg, m_dp);
      end
      if (st % FRAME == FRAME - 1) begin
        checks++; if (lit0 != ((((st / FRAME) % 4) < 2) ? SLOT : 0)) begin
          errors++; $display("FAIL blink_frame%0d: lit=%0d", st / FRAME, lit0);
        end
        lit0 = 0;
      end
    end
  endtask

  task automatic test_reset_midframe();
    while (m_t % FRAME != 30) tick();
    digits = 16'h9999; blank = 4'h0; blink = 4'h0; update = 1'b1; tick(); update = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_pre: got %b want 1", busy); end
    reset = 1'b0; tick();
    checks++; if (busy !== 1'b0 || an !== 4'hF) begin
      errors++; $display("FAIL rstmid_busy: busy=%b an=%b want 0 1111", busy, an);
    end
    reset = 1'b1;
    for (int c = 0; c < 2 * FRAME; c++) begin
      tick();
      checks++; if (an !== 4'hF || busy !== 1'b0) begin
        errors++; $display("FAIL rstmid_dark_c%0d: an=%b busy=%b", c, an, busy);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      update = ($urandom_range(0, 7) == 0);
      digits = 16'($urandom);
      dp_in = 4'($urandom); blank = 4'($urandom_range(0, 15) & 4'($urandom));
      blink = 4'($urandom);
      if ($urandom_range(0, 40) == 0) brightness = 4'($urandom);
      reset = ($urandom_range(0, 999) != 0);
      tick();
      checks++;
      if (an !== m_an || seg !== m_seg || dp !== m_dp || frame_start !== m_fs || busy !== m_busy) begin
        errors++;
        $display("FAIL random_c%0d: an=%b seg=%b dp=%b fs=%b busy=%b want %b %b %b %b %b",
                 c, an, seg, dp, frame_start, busy, m_an, m_seg, m_dp, m_fs, m_busy);
      end
    end
    reset = 1'b1; update = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_shadow();
    test_boundary_update();
    test_brightness();
    test_blank_blink_dp();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
